// File: rtl/rv_burst_source.sv
// rv_burst_source: valid/ready transmitter that emits a burst of incrementing
// words on a start pulse. It honours downstream back-pressure and can insert
// a programmable idle gap after every accepted non-final word.
module rv_burst_source #(
    parameter int wd = 4,
    parameter int lw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [wd-1:0] start_val,
    input  logic [lw-1:0] burst_len,
    input  logic [3:0]    gap,
    output logic [wd-1:0] dataout,
    output logic          dataout_val,
    input  logic          dataout_rdy,
    output logic          busy,
    output logic          done,
    output logic [lw-1:0] sent_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t        state;
    logic [lw-1:0] len_q;
    logic [3:0]    gap_q;
    logic [3:0]    gap_cnt;
    logic [lw-1:0] sent_next;

    // Count after the transfer in flight; a match with the latched length marks the last word.
    assign sent_next = sent_cnt + lw'(1);

    // Burst FSM with registered outputs; valid depends only on state, never on ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            len_q       <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            dataout     <= '0;
            dataout_val <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sent_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sent_cnt <= '0;
                        if (burst_len != '0) begin
                            len_q       <= burst_len;
                            gap_q       <= gap;
                            dataout     <= start_val;
                            dataout_val <= 1'b1;
                            busy        <= 1'b1;
                            state       <= S_SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (dataout_rdy) begin
                        sent_cnt <= sent_next;
                        if (sent_next == len_q) begin
                            dataout_val <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= S_IDLE;
                        end else if (gap_q == 4'd0) begin
                            dataout <= dataout + wd'(1);
                        end else begin
                            dataout_val <= 1'b0;
                            gap_cnt     <= gap_q;
                            state       <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd1) begin
                        dataout     <= dataout + wd'(1);
                        dataout_val <= 1'b1;
                        state       <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    dataout_val <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_burst_source.sv
// Testbench for rv_burst_source: scenario tasks compare the DUT against a
// word-by-word model of the burst (expected word = start value + index,
// G invalid cycles after each accepted non-final word, done one cycle after
// the last transfer).
module tb_rv_burst_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] start_val;
    logic [7:0] burst_len;
    logic [3:0] gap;
    logic [3:0] dataout;
    logic       dataout_val;
    logic       dataout_rdy;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;

    int checks = 0;
    int errors = 0;

    rv_burst_source #(.wd(4), .lw(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_val(start_val),
        .burst_len(burst_len),
        .gap(gap),
        .dataout(dataout),
        .dataout_val(dataout_val),
        .dataout_rdy(dataout_rdy),
        .busy(busy),
        .done(done),
        .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    // Launch a burst at the current negedge and follow it until done, checking
    // every cycle against the model. Ends at the negedge of the done cycle.
    task automatic drive_burst(input logic [3:0] sv, input logic [7:0] len, input logic [3:0] gp,
                               input logic [15:0] rpat, input int rpat_len, input bit rnd_rdy,
                               input int mid_cyc, input string name, output int cyc_to_done);
        int   cnt;
        int   gap_left;
        int   cyc;
        bit   finished;
        bit   exp_val;
        logic r;
        logic [3:0] exp_word;
        start = 1'b1; start_val = sv; burst_len = len; gap = gp;
        cnt = 0; gap_left = 0; cyc = 0; finished = 0; cyc_to_done = -1;
        while (!finished && cyc < 1000) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) begin
                start_val = 4'($urandom); burst_len = 8'($urandom); gap = 4'($urandom);
            end
            if (cnt == int'(len)) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL %s done_pulse: got %b want 1", name, done); end
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s busy_end: got %b want 0", name, busy); end
                checks++; if (dataout_val !== 1'b0) begin errors++; $display("[TB] FAIL %s val_end: got %b want 0", name, dataout_val); end
                checks++; if (sent_cnt !== len) begin errors++; $display("[TB] FAIL %s sent_final: got %0d want %0d", name, sent_cnt, len); end
                finished = 1;
                cyc_to_done = cyc;
            end else begin
                checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s done_early: got %b want 0 at cyc %0d", name, done, cyc); end
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busy: got %b want 1 at cyc %0d", name, busy, cyc); end
                checks++; if (sent_cnt !== 8'(cnt)) begin errors++; $display("[TB] FAIL %s sent_cnt: got %0d want %0d at cyc %0d", name, sent_cnt, cnt, cyc); end
                exp_val = (gap_left == 0);
                if (!exp_val) begin
                    checks++; if (dataout_val !== 1'b0) begin errors++; $display("[TB] FAIL %s gap_val: got %b want 0 at cyc %0d", name, dataout_val, cyc); end
                    gap_left--;
                end else begin
                    exp_word = sv + 4'(cnt);
                    checks++; if (dataout_val !== 1'b1) begin errors++; $display("[TB] FAIL %s val: got %b want 1 at cyc %0d", name, dataout_val, cyc); end
                    checks++; if (dataout !== exp_word) begin errors++; $display("[TB] FAIL %s data: got %h want %h at cyc %0d", name, dataout, exp_word, cyc); end
                end
                if (cyc < rpat_len) r = rpat[cyc];
                else if (rnd_rdy) r = 1'($urandom_range(0, 1));
                else r = 1'b1;
                dataout_rdy = r;
                if (exp_val && r) begin
                    cnt++;
                    if (cnt < int'(len)) gap_left = int'(gp);
                end
                if (cyc == mid_cyc) begin
                    start = 1'b1; start_val = 4'($urandom); burst_len = 8'($urandom_range(1, 255)); gap = 4'($urandom);
                end
            end
            cyc++;
        end
        if (!finished) begin
            errors++; checks++;
            $display("[TB] FAIL %s timeout: got no done want done within 1000 cycles", name);
        end
    endtask

    // Outputs are zero while reset is held; reset is released at a negedge.
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_val = '0; burst_len = '0; gap = '0; dataout_rdy = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({dataout, dataout_val, busy, done, sent_cnt} !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h want 0000", {dataout, dataout_val, busy, done, sent_cnt});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || dataout_val !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_idle: got busy=%b val=%b want 0 0", busy, dataout_val);
        end
    endtask

    task automatic test_basic();
        int c;
        drive_burst(4'd3, 8'd5, 4'd0, 16'h0, 0, 1'b0, -1, "basic", c);
        checks++; if (c !== 5) begin errors++; $display("[TB] FAIL basic_len_cycles: got %0d want 5", c); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_once: got %b want 0", done); end
        checks++; if (sent_cnt !== 8'd5) begin errors++; $display("[TB] FAIL basic_sent_hold: got %0d want 5", sent_cnt); end
    endtask

    task automatic test_backpressure();
        int c;
        // rdy sequence 1,0,0,1,0,1,1 packed LSB first
        drive_burst(4'd0, 8'd4, 4'd0, 16'b1101001, 7, 1'b0, -1, "backpressure", c);
        checks++; if (c !== 7) begin errors++; $display("[TB] FAIL bp_cycles: got %0d want 7", c); end
    endtask

    task automatic test_wrap_gap();
        int c;
        drive_burst(4'hE, 8'd4, 4'd2, 16'h0, 0, 1'b0, -1, "wrap_gap", c);
        checks++; if (c !== 10) begin errors++; $display("[TB] FAIL wrap_gap_cycles: got %0d want 10", c); end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start = 1'b1; start_val = 4'h7; burst_len = 8'd0; gap = 4'd0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b want 1", done); end
        checks++; if (dataout_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_val_busy: got %b %b want 0 0", dataout_val, busy); end
        checks++; if (sent_cnt !== 8'd0) begin errors++; $display("[TB] FAIL zero_sent: got %0d want 0", sent_cnt); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || dataout_val !== 1'b0) begin errors++; $display("[TB] FAIL zero_after: got done=%b val=%b want 0 0", done, dataout_val); end
    endtask

    task automatic test_ignored_start();
        int c;
        drive_burst(4'h6, 8'd6, 4'd1, 16'h0, 0, 1'b1, 2, "ignored_start", c);
        drive_burst(4'hA, 8'd3, 4'd0, 16'h0, 0, 1'b0, 0, "ignored_start2", c);
    endtask

    task automatic test_back_to_back();
        int c;
        drive_burst(4'h1, 8'd3, 4'd0, 16'h0, 0, 1'b0, -1, "b2b_first", c);
        drive_burst(4'hC, 8'd2, 4'd1, 16'h0, 0, 1'b0, -1, "b2b_second", c);
    endtask

    task automatic test_reset_mid();
        int c;
        logic [3:0] w;
        start = 1'b1; start_val = 4'h5; burst_len = 8'd8; gap = 4'd0; dataout_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            w = 4'h5 + 4'(i);
            checks++; if (dataout !== w || dataout_val !== 1'b1) begin
                errors++; $display("[TB] FAIL rstmid_word%0d: got %h/%b want %h/1", i, dataout, dataout_val, w);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({dataout, dataout_val, busy, done, sent_cnt} !== 16'h0) begin
            errors++; $display("[TB] FAIL rstmid_async: got %h want 0000", {dataout, dataout_val, busy, done, sent_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || dataout_val !== 1'b0) begin
                errors++; $display("[TB] FAIL rstmid_quiet: got done=%b val=%b want 0 0", done, dataout_val);
            end
        end
        drive_burst(4'd9, 8'd3, 4'd0, 16'h0, 0, 1'b0, -1, "rstmid_restart", c);
    endtask

    task automatic test_random();
        int c;
        logic [7:0] len;
        for (int n = 0; n < 20; n++) begin
            len = 8'($urandom_range(1, 12));
            drive_burst(4'($urandom), len, 4'($urandom_range(0, 3)), 16'h0, 0, 1'b1,
                        int'($urandom_range(0, 8)), "random", c);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                checks++; if (done !== 1'b0 || sent_cnt !== len) begin
                    errors++; $display("[TB] FAIL random_hold: got done=%b sent=%0d want 0 %0d", done, sent_cnt, len);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_gap();
        test_zero_len();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
